// File: rtl/crc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : crc_pkg
// Description : Shared types and polynomial constants for the CRC encoder.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package crc_pkg;

   // Transaction controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Common generator polynomials, implicit top term omitted
   localparam logic [3:0]  CRC4_ITU    = 4'h3;
   localparam logic [7:0]  CRC8        = 8'h07;
   localparam logic [15:0] CRC16_CCITT = 16'h1021;

endpackage
`default_nettype wire

// File: rtl/crc_lfsr_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : crc_lfsr_core
// Description : Serial Galois-form CRC register, one message bit per step.
//               crc_next exposes the value the register takes on the next step.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module crc_lfsr_core #(
   parameter int               CRC_W = 4,
   parameter logic [CRC_W-1:0] POLY  = 'h3,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             step,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc,
   output logic [CRC_W-1:0] crc_next
);

   logic [CRC_W-1:0] r_crc;
   logic             w_fb;

   // Feedback combines the outgoing CRC bit with the incoming message bit
   always_comb begin
      w_fb     = r_crc[CRC_W-1] ^ bit_in;
      crc_next = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : {CRC_W{1'b0}});
   end

   // CRC register: seeded at transaction start, advanced once per step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_crc <= '0;
      end else if (init) begin
         r_crc <= INIT;
      end else if (step) begin
         r_crc <= crc_next;
      end
   end

   assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/crc_param_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : crc_param_encoder
// Description : Handshaked bit-serial CRC generator/checker. Captures one
//               data word and address, shifts the data MSB-first through the
//               CRC register and returns {data, crc}; in check mode flags a
//               difference against the supplied CRC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module crc_param_encoder
   import crc_pkg::*;
#(
   parameter int               DATA_W = 8,
   parameter int               ADDR_W = 4,
   parameter int               CRC_W  = 4,
   parameter logic [CRC_W-1:0] POLY   = 'h3,
   parameter logic [CRC_W-1:0] INIT   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [ADDR_W-1:0]       in_addr,
   input  logic                    in_check,
   input  logic [CRC_W-1:0]        in_crc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W+CRC_W-1:0] data_out,
   output logic [ADDR_W-1:0]       addr_out,
   output logic                    crc_err
);

   localparam int c_CNT_W = $clog2(DATA_W) + 1;

   // Reject configurations the serial datapath cannot implement
   if (CRC_W < 2) begin : g_chk_crc_w
      $error("crc_param_encoder: CRC_W must be at least 2");
   end
   if (DATA_W < 1) begin : g_chk_data_w
      $error("crc_param_encoder: DATA_W must be at least 1");
   end
   if (POLY[0] != 1'b1) begin : g_chk_poly
      $error("crc_param_encoder: POLY bit 0 must be set");
   end

   state_t              r_state;
   state_t              w_state_next;
   logic [DATA_W-1:0]   r_shreg;
   logic [DATA_W-1:0]   r_data;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_check;
   logic [CRC_W-1:0]    r_crc_in;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_crc_err;
   logic                w_accept;
   logic                w_step;
   logic                w_last;
   logic                w_out_fire;
   logic [CRC_W-1:0]    w_crc;
   logic [CRC_W-1:0]    w_crc_next;

   assign w_accept   = (r_state == IDLE) && in_valid;
   assign w_step     = (r_state == SHIFT);
   assign w_last     = w_step && (r_cnt == '0);
   assign w_out_fire = (r_state == DONE) && out_ready;

   crc_lfsr_core #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .INIT  (INIT)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .init     (w_accept),
      .step     (w_step),
      .bit_in   (r_shreg[DATA_W-1]),
      .crc      (w_crc),
      .crc_next (w_crc_next)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a request seen in DONE waits for the following IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)   w_state_next = SHIFT;
         SHIFT:   if (r_cnt == '0) w_state_next = DONE;
         DONE:    if (out_ready)  w_state_next = IDLE;
         default:                 w_state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Capture registers and bit counter; the shift register feeds the CRC MSB-first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shreg  <= '0;
         r_data   <= '0;
         r_addr   <= '0;
         r_check  <= 1'b0;
         r_crc_in <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_shreg  <= in_data;
         r_data   <= in_data;
         r_addr   <= in_addr;
         r_check  <= in_check;
         r_crc_in <= in_crc;
         r_cnt    <= c_CNT_W'(DATA_W - 1);
      end else if (w_step) begin
         r_shreg  <= r_shreg << 1;
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
         end
      end
   end

   // Mismatch flag is taken from the final CRC value as DONE is entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_crc_err <= 1'b0;
      end else if (w_last) begin
         r_crc_err <= r_check && (w_crc_next != r_crc_in);
      end else if (w_out_fire) begin
         r_crc_err <= 1'b0;
      end
   end

   assign data_out = {r_data, w_crc};
   assign addr_out = r_addr;
   assign crc_err  = r_crc_err;

endmodule
`default_nettype wire

// File: tb/tb_crc_param_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_crc_param_encoder
// Description : Self-checking bench for crc_param_encoder: directed table,
//               backpressure/reset sequences, a CRC-16 instance and random
//               traffic against a polynomial-division reference.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_crc_param_encoder;

   logic        clk = 1'b0;
   logic        rst;

   // Default configuration instance
   logic        in_valid, in_ready, in_check, out_valid, out_ready, crc_err;
   logic [7:0]  in_data;
   logic [3:0]  in_addr, in_crc, addr_out;
   logic [11:0] data_out;

   // CRC-16/CCITT instance
   logic        v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_crc_err;
   logic [15:0] v2_in_data, v2_in_crc;
   logic [3:0]  v2_in_addr, v2_addr_out;
   logic [31:0] v2_data_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   crc_param_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_addr   (in_addr),
      .in_check  (in_check),
      .in_crc    (in_crc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .addr_out  (addr_out),
      .crc_err   (crc_err)
   );

   crc_param_encoder #(
      .DATA_W (16),
      .ADDR_W (4),
      .CRC_W  (16),
      .POLY   (16'h1021),
      .INIT   (16'hFFFF)
   ) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v2_in_valid),
      .in_ready  (v2_in_ready),
      .in_data   (v2_in_data),
      .in_addr   (v2_in_addr),
      .in_check  (1'b0),
      .in_crc    (v2_in_crc),
      .out_valid (v2_out_valid),
      .out_ready (v2_out_ready),
      .data_out  (v2_data_out),
      .addr_out  (v2_addr_out),
      .crc_err   (v2_crc_err)
   );

   // Reference: remainder of (init*x^dw + data*x^cw) divided by the generator
   function automatic logic [63:0] crc_ref(input int dw, input int cw,
                                           input logic [63:0] poly,
                                           input logic [63:0] init,
                                           input logic [63:0] data);
      logic [63:0] m;
      logic [63:0] g;
      m = (init << dw) ^ (data << cw);
      g = (64'd1 << cw) | poly;
      for (int b = dw + cw - 1; b >= cw; b--) begin
         if (m[b]) m = m ^ (g << (b - cw));
      end
      return m & ((64'd1 << cw) - 64'd1);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One complete transaction on the default instance, out_ready low until result seen
   task automatic txn1(input string nm, input logic [7:0] d, input logic [3:0] a,
                       input logic chk, input logic [3:0] ci,
                       input logic [11:0] exp_do, input logic exp_err);
      int cyc;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      in_valid = 1'b1; in_data = d; in_addr = a; in_check = chk; in_crc = ci;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      check({nm, "_latency"}, 64'(cyc), 64'd9);
      check({nm, "_data"}, 64'(data_out), 64'(exp_do));
      check({nm, "_addr"}, 64'(addr_out), 64'(a));
      check({nm, "_err"}, 64'(crc_err), 64'(exp_err));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({nm, "_released"}, 64'(out_valid), 64'd0);
   endtask

   typedef struct {
      logic [7:0]  d;
      logic [3:0]  a;
      logic        chk;
      logic [3:0]  ci;
      logic [11:0] exp_do;
      logic        exp_err;
   } vec_t;

   vec_t tbl[6];

   typedef struct {
      logic [11:0] dout;
      logic [3:0]  addr;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   initial begin
      int          cyc;
      int          sent;
      int          recv;
      logic [63:0] e64;
      exp_t        e;

      tbl[0] = '{8'h01, 4'h1, 1'b0, 4'h0, 12'h013, 1'b0};
      tbl[1] = '{8'h80, 4'h2, 1'b0, 4'h0, 12'h80E, 1'b0};
      tbl[2] = '{8'hFF, 4'h3, 1'b0, 4'h0, 12'hFF4, 1'b0};
      tbl[3] = '{8'h00, 4'h4, 1'b0, 4'h0, 12'h000, 1'b0};
      tbl[4] = '{8'hFF, 4'h5, 1'b1, 4'h4, 12'hFF4, 1'b0};
      tbl[5] = '{8'hFF, 4'h6, 1'b1, 4'h5, 12'hFF4, 1'b1};

      rst = 1'b0;
      in_valid = 1'b0; in_data = '0; in_addr = '0; in_check = 1'b0; in_crc = '0;
      out_ready = 1'b0;
      v2_in_valid = 1'b0; v2_in_data = '0; v2_in_addr = '0; v2_in_crc = '0;
      v2_out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_addr_out", 64'(addr_out), 64'd0);
      check("rst_crc_err", 64'(crc_err), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Directed encode/check vectors
      foreach (tbl[i]) begin
         txn1($sformatf("vec%0d", i), tbl[i].d, tbl[i].a, tbl[i].chk, tbl[i].ci,
              tbl[i].exp_do, tbl[i].exp_err);
      end

      // Backpressure with a competing request held through DONE
      e64 = crc_ref(8, 4, 64'h3, 64'h0, 64'h5A);
      in_valid = 1'b1; in_data = 8'h5A; in_addr = 4'h3; in_check = 1'b0;
      @(posedge clk); #1;
      in_data = 8'hA5; in_addr = 4'hC;
      cyc = 1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_data", 64'(data_out), {52'h0, 8'h5A, e64[3:0]});
         check("bp_hold_addr", 64'(addr_out), 64'h3);
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_after_hs_valid", 64'(out_valid), 64'd0);
      check("bp_after_hs_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_second_accepted", 64'(in_ready), 64'd0);
      check("bp_second_data_hi", 64'(data_out[11:4]), 64'hA5);
      check("bp_second_addr", 64'(addr_out), 64'hC);
      e64 = crc_ref(8, 4, 64'h3, 64'h0, 64'hA5);
      cyc = 1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      check("bp_second_latency", 64'(cyc), 64'd9);
      check("bp_second_result", 64'(data_out), {52'h0, 8'hA5, e64[3:0]});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of SHIFT aborts the transaction
      in_valid = 1'b1; in_data = 8'hC3; in_addr = 4'h7; in_check = 1'b1; in_crc = 4'h0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_data_out", 64'(data_out), 64'd0);
      check("midrst_addr_out", 64'(addr_out), 64'd0);
      check("midrst_crc_err", 64'(crc_err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      txn1("post_rst", 8'h01, 4'h2, 1'b0, 4'h0, 12'h013, 1'b0);

      // CRC-16/CCITT, INIT=FFFF, ASCII "12"
      e64 = crc_ref(16, 16, 64'h1021, 64'hFFFF, 64'h3132);
      v2_in_valid = 1'b1; v2_in_data = 16'h3132; v2_in_addr = 4'h9;
      @(posedge clk); #1;
      v2_in_valid = 1'b0;
      cyc = 1;
      while (!v2_out_valid && cyc < 60) begin
         @(posedge clk); #1; cyc++;
      end
      check("crc16_latency", 64'(cyc), 64'd17);
      check("crc16_data", 64'(v2_data_out), {32'h0, 16'h3132, e64[15:0]});
      check("crc16_addr", 64'(v2_addr_out), 64'h9);
      check("crc16_err", 64'(v2_crc_err), 64'd0);
      v2_out_ready = 1'b1;
      @(posedge clk); #1;
      v2_out_ready = 1'b0;

      // Random back-to-back traffic with random backpressure
      sent = 0; recv = 0; cyc = 0;
      while (recv < 1000 && cyc < 60000) begin
         @(posedge clk); #1;
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
         in_data   = 8'($urandom);
         in_addr   = 4'($urandom);
         in_check  = 1'($urandom);
         e64       = crc_ref(8, 4, 64'h3, 64'h0, 64'(in_data));
         in_crc    = ($urandom_range(0, 1) != 0) ? e64[3:0] : 4'($urandom);
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_spurious_output", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("rnd_result", {47'h0, data_out, addr_out, crc_err},
                     {47'h0, e.dout, e.addr, e.err});
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            e.dout = {in_data, e64[3:0]};
            e.addr = in_addr;
            e.err  = in_check && (e64[3:0] != in_crc);
            exp_q.push_back(e);
            sent++;
         end
      end
      check("rnd_received", 64'(recv), 64'd1000);
      check("rnd_sent", 64'(sent), 64'd1000);
      check("rnd_leftover", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc_param_encoder.md
# crc_param_encoder

Parametrised, handshaked CRC generator/checker for the memory-protection path. Accepts one data word plus address per transaction. Shifts the data MSB-first through a CRC_W-bit LFSR with a configurable generator polynomial. Returns the codeword {data, crc} with the address. In check mode it also compares the computed CRC against a supplied one and flags a mismatch. It sits between the memory write port (encode) and read port (check) in place of fixed-width CRC-4 encoders.

## Interface
- DATA_W, 8, data word width (≥1)
- ADDR_W, 4, address width (≥1)
- CRC_W, 4, CRC width (≥2)
- POLY, 'h3, generator polynomial without the implicit x^CRC_W term; bit 0 must be 1 (default x^4+x+1)
- INIT, 0, LFSR value loaded at transaction start
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_data  in  DATA_W  data word
- in_addr  in  ADDR_W  address
- in_check  in  1  0 = encode, 1 = check against in_crc
- in_crc  in  CRC_W  received CRC (check mode only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- data_out  out  DATA_W+CRC_W  {data, computed crc}
- addr_out  out  ADDR_W  captured address
- crc_err  out  1  check mode: computed ≠ in_crc; always 0 in encode mode

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid, capture data, addr, check and in_crc. Load the shift register with in_data, set the LFSR to INIT and the counter to DATA_W-1, then go to SHIFT.
  - SHIFT: one bit per cycle, MSB-first.
    - fb = lfsr[CRC_W-1] ^ shreg[DATA_W-1]
    - lfsr ← {lfsr[CRC_W-2:0],0} ^ (fb ? POLY : 0)
    - shreg ← shreg << 1
    - When the counter reaches 0, go to DONE. Otherwise decrement the counter.
  - DONE: out_valid=1; outputs stay stable until out_ready. On out_valid & out_ready, go to IDLE.
- The result equals (data·x^CRC_W + INIT-contribution) mod G; with INIT=0 it is the standard non-reflected CRC with no final XOR.
- crc_err is registered on entry to DONE as check & (lfsr_next ≠ in_crc_captured). It is cleared on leaving DONE.
- in_ready is 0 in SHIFT and DONE. Requests there are ignored, not queued.
- Counter width is $clog2(DATA_W)+1 bits. DATA_W=1 gives exactly one SHIFT cycle.

## Timing
- Reset (rst=0, asynchronous):
  - state = IDLE; lfsr, shift register, counter, data_out, addr_out, crc_err = 0; out_valid = 0; in_ready = 1 after deassertion.
  - Reset in the middle of SHIFT or DONE aborts the transaction. No output is produced.
- Latency: accept edge at cycle 0, SHIFT cycles 1…DATA_W, out_valid high from cycle DATA_W+1.
- Minimum issue interval is DATA_W+2 cycles with out_ready held high.
- Backpressure: out_valid, data_out, addr_out and crc_err are held unchanged while out_ready=0.
- data_out[DATA_W+CRC_W-1:CRC_W] and addr_out update only at accept, so they are valid from cycle 1 onward. The CRC field is final only when out_valid=1.
- Simultaneous out handshake and in_valid in DONE: only the output completes. The request is accepted in the following IDLE cycle.

## Structure
- Shared package crc_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - polynomial constants CRC4_ITU='h3, CRC8='h07, CRC16_CCITT='h1021.
- Elaboration-time checks: CRC_W≥2, DATA_W≥1, POLY[0]=1.
- One natural sub-module, crc_lfsr_core (parameters CRC_W, POLY, INIT). Its ports are clk, rst, init, step, bit_in, crc, crc_next. The top-level holds the FSM, counter, shift register and capture registers.

## Test plan
- Defaults, encode 0x01, INIT=0 → out_valid at cycle 9, data_out=0x013, crc_err=0. Encode 0x80 → data_out=0x80E. Encode 0xFF → data_out=0xFF4. Encode 0x00 → 0x000.
- Check mode, data 0xFF: in_crc=0x4 → crc_err=0; in_crc=0x5 → crc_err=1, data_out=0xFF4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → outputs stable, in_ready=0, no second transaction. Release → new request accepted one cycle after the handshake.
- Assert rst mid-SHIFT (cycle 4) → all outputs 0 immediately. After release, encoding 0x01 gives 0x013 with no residue from the aborted transaction.
- DATA_W=16, CRC_W=16, POLY='h1021, INIT='hFFFF, ASCII "12" (0x3132) → CRC matches a software bitwise model; out_valid at cycle 17.
- Randomised back-to-back traffic (≥1000 transactions, random out_ready) → every result matches the reference model, addr_out matches the paired address, and no transaction is lost or duplicated.
